rvc_asap_vga_mem_arb: RTL

Arbiter and sequencer for the single-port VGA memory (byte region 0x8000–0x115FF, 9600 32-bit words). It shares the memory between the core data port and the display fetch engine, with display priority and a bounded-wait guarantee for the core. It decodes core byte addresses to word indices, drives the memory control signals and routes the 1-cycle-latency read data back to the owner. It sits between the core's memory-region decode and the VGA memory instance.

---
 rtl/rvc_asap_vga_mem_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rvc_asap_vga_mem_arb.sv
// Arbiter/sequencer for the single-port VGA memory: display has priority, core
// has a bounded wait. Decodes core byte addresses and routes 1-cycle read data.
module rvc_asap_vga_mem_arb #(
  parameter logic [31:0] VGA_BASE  = 32'h8000,
  parameter int          MEM_WORDS = 9600,
  parameter int          ADDR_W    = 14,
  parameter int          MAX_WAIT  = 4
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              CoreReq,
  input  logic              CoreWrEn,
  input  logic [31:0]       CoreAddr,
  input  logic [3:0]        CoreByteEn,
  input  logic [31:0]       CoreWrData,
  output logic              CoreGnt,
  output logic              CoreRdValid,
  output logic [31:0]       CoreRdData,
  output logic              CoreErr,
  input  logic              DispReq,
  input  logic [ADDR_W-1:0] DispAddr,
  output logic              DispGnt,
  output logic              DispRdValid,
  output logic [31:0]       DispRdData,
  output logic              MemEn,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemByteEn,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_DISP = 2'd2
  } ret_tag_e;

  logic [31:0] core_offset;
  logic [31:0] core_index;
  logic        core_illegal;
  logic        core_win;
  logic        core_gnt;
  logic        disp_gnt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;
  ret_tag_e    tag;
  ret_tag_e    tag_next;
  logic        zero_q;
  logic        zero_next;

  assign core_offset  = CoreAddr - VGA_BASE;
  assign core_index   = core_offset >> 2;
  assign core_illegal = (CoreAddr < VGA_BASE) ||
                        (core_index >= 32'(MEM_WORDS)) ||
                        (CoreAddr[1:0] != 2'b00);

  // Core wins when the display is idle or the core has waited long enough.
  assign core_win = ~DispReq || (wait_cnt >= 4'(MAX_WAIT));
  assign core_gnt = ~Rst & CoreReq & core_win;
  assign disp_gnt = ~Rst & DispReq & ~(CoreReq & core_win);

  assign CoreGnt = core_gnt;
  assign DispGnt = disp_gnt;
  assign CoreErr = core_gnt & core_illegal;

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!CoreReq || core_gnt) begin
      wait_cnt_next = 4'd0;
    end else if (disp_gnt) begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  always_comb begin
    MemEn     = 1'b0;
    MemWrEn   = 1'b0;
    MemAddr   = '0;
    MemByteEn = 4'h0;
    MemWrData = 32'h0;
    if (disp_gnt) begin
      MemEn     = 1'b1;
      MemAddr   = DispAddr;
      MemByteEn = 4'hF;
    end else if (core_gnt && !core_illegal) begin
      MemEn     = 1'b1;
      MemWrEn   = CoreWrEn;
      MemAddr   = core_index[ADDR_W-1:0];
      MemByteEn = CoreWrEn ? CoreByteEn : 4'hF;
      MemWrData = CoreWrData;
    end
  end

  // Illegal loads still return, but with the data forced to zero.
  always_comb begin
    tag_next  = TAG_NONE;
    zero_next = 1'b0;
    if (disp_gnt) begin
      tag_next = TAG_DISP;
    end else if (core_gnt && !CoreWrEn) begin
      tag_next  = TAG_CORE;
      zero_next = core_illegal;
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      wait_cnt <= 4'd0;
      tag      <= TAG_NONE;
      zero_q   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      tag      <= tag_next;
      zero_q   <= zero_next;
    end
  end

  assign CoreRdValid = ~Rst & (tag == TAG_CORE);
  assign DispRdValid = ~Rst & (tag == TAG_DISP);
  assign CoreRdData  = (CoreRdValid && !zero_q) ? MemRdData : 32'h0;
  assign DispRdData  = DispRdValid ? MemRdData : 32'h0;

endmodule
